// File: rtl/game_pkg.sv
// Shared game-flow types and widths used by the overlay sequencer and score HUD.
package game_pkg;

   localparam int POINTS_W = 5;
   localparam int LIVES_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PLAYING = 2'd1,
      ST_GO_HOLD = 2'd2,
      ST_GO_WAIT = 2'd3
   } game_state_t;

endpackage

// File: rtl/bin_to_bcd2.sv
// Combinational binary score to tens/units split by compare-subtract (score < 40).
module bin_to_bcd2
   import game_pkg::*;
(
   input  logic [POINTS_W-1:0] bin,
   output logic [3:0]          tens,
   output logic [3:0]          units
);

   logic [POINTS_W-1:0] rem;

   always_comb begin
      tens = 4'd0;
      rem  = bin;
      if (bin >= POINTS_W'(30)) begin
         tens = 4'd3;
         rem  = bin - POINTS_W'(30);
      end else if (bin >= POINTS_W'(20)) begin
         tens = 4'd2;
         rem  = bin - POINTS_W'(20);
      end else if (bin >= POINTS_W'(10)) begin
         tens = 4'd1;
         rem  = bin - POINTS_W'(10);
      end
      units = 4'(rem);
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// IDLE/PLAYING/GAME_OVER sequencer with score, lives and registered overlay outputs.
// Optional blinking game-over overlay: define GAME_OVER_BLINK_EN.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int unsigned LIVES_INIT   = 3,
   parameter int unsigned MAX_POINTS   = 31,
   parameter int unsigned HOLD_FRAMES  = 120,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_btn,
   input  logic                hit_evt,
   input  logic                miss_evt,
   input  logic                frame_tick,
   output logic                playing,
   output logic                game_over,
   output logic                display_en,
   output logic [POINTS_W-1:0] points,
   output logic [3:0]          points_tens,
   output logic [3:0]          points_units,
   output logic [LIVES_W-1:0]  lives
);

   game_state_t         state, state_nxt;
   logic                start_q, start_rise;
   logic [POINTS_W-1:0] points_nxt;
   logic [LIVES_W-1:0]  lives_nxt;
   logic [7:0]          frame_cnt, frame_cnt_nxt;
   logic [3:0]          tens_nxt, units_nxt;
   logic                playing_d, game_over_d, display_en_d, blink_on;
   logic                go_entry, in_go;

   assign start_rise = start_btn & ~start_q;
   assign in_go      = (state == ST_GO_HOLD) || (state == ST_GO_WAIT);
   assign go_entry   = (state == ST_PLAYING) && (state_nxt == ST_GO_HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         start_q   <= 1'b0;
         points    <= '0;
         lives     <= LIVES_W'(LIVES_INIT);
         frame_cnt <= '0;
      end else begin
         state     <= state_nxt;
         start_q   <= start_btn;
         points    <= points_nxt;
         lives     <= lives_nxt;
         frame_cnt <= frame_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      points_nxt    = points;
      lives_nxt     = lives;
      frame_cnt_nxt = '0;
      case (state)
         ST_IDLE, ST_GO_WAIT: begin
            if (start_rise) begin
               points_nxt = '0;
               lives_nxt  = LIVES_W'(LIVES_INIT);
               state_nxt  = ST_PLAYING;
            end
         end
         ST_PLAYING: begin
            if (hit_evt && (points < POINTS_W'(MAX_POINTS)))
               points_nxt = points + 1'b1;
            if (miss_evt) begin
               lives_nxt = lives - 1'b1;
               if (lives == LIVES_W'(1))
                  state_nxt = ST_GO_HOLD;
            end
         end
         ST_GO_HOLD: begin
            frame_cnt_nxt = frame_cnt;
            if (frame_tick) begin
               frame_cnt_nxt = frame_cnt + 1'b1;
               if (frame_cnt == 8'(HOLD_FRAMES - 1))
                  state_nxt = ST_GO_WAIT;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef GAME_OVER_BLINK_EN
   logic [7:0] blink_cnt, blink_cnt_nxt;
   logic       blink_ph, blink_ph_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b1;
      end else begin
         blink_cnt <= blink_cnt_nxt;
         blink_ph  <= blink_ph_nxt;
      end
   end

   // Phase restarts high on every game-over entry, then flips every BLINK_FRAMES ticks.
   always_comb begin
      blink_cnt_nxt = blink_cnt;
      blink_ph_nxt  = blink_ph;
      if (go_entry) begin
         blink_cnt_nxt = '0;
         blink_ph_nxt  = 1'b1;
      end else if (in_go && frame_tick) begin
         if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
            blink_cnt_nxt = '0;
            blink_ph_nxt  = ~blink_ph;
         end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
         end
      end
   end

   assign blink_on = blink_ph_nxt;
`else
   assign blink_on = 1'b1;
`endif

   bin_to_bcd2 u_bcd (
      .bin   (points_nxt),
      .tens  (tens_nxt),
      .units (units_nxt)
   );

   always_comb begin
      playing_d    = (state_nxt == ST_PLAYING);
      game_over_d  = (state_nxt == ST_GO_HOLD) || (state_nxt == ST_GO_WAIT);
      display_en_d = game_over_d & blink_on;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         playing      <= 1'b0;
         game_over    <= 1'b0;
         display_en   <= 1'b0;
         points_tens  <= 4'd0;
         points_units <= 4'd0;
      end else begin
         playing      <= playing_d;
         game_over    <= game_over_d;
         display_en   <= display_en_d;
         points_tens  <= tens_nxt;
         points_units <= units_nxt;
      end
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed flow plus random events against a behavioural model.
module tb_game_flow_ctrl;

   localparam int LIVES_INIT   = 3;
   localparam int MAX_POINTS   = 31;
   localparam int HOLD_FRAMES  = 120;
   localparam int BLINK_FRAMES = 30;

   localparam int M_IDLE = 0, M_PLAY = 1, M_HOLD = 2, M_WAIT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_btn = 1'b0, hit_evt = 1'b0, miss_evt = 1'b0, frame_tick = 1'b0;
   logic       playing, game_over, display_en;
   logic [4:0] points;
   logic [3:0] points_tens, points_units;
   logic [2:0] lives;

   int errors = 0;
   int checks = 0;

   int m_st, m_pts, m_lives, m_ticks;
   bit m_sq;

   always #5 clk = ~clk;

   game_flow_ctrl #(
      .LIVES_INIT   (LIVES_INIT),
      .MAX_POINTS   (MAX_POINTS),
      .HOLD_FRAMES  (HOLD_FRAMES),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_btn    (start_btn),
      .hit_evt      (hit_evt),
      .miss_evt     (miss_evt),
      .frame_tick   (frame_tick),
      .playing      (playing),
      .game_over    (game_over),
      .display_en   (display_en),
      .points       (points),
      .points_tens  (points_tens),
      .points_units (points_units),
      .lives        (lives)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_pts = 0; m_lives = LIVES_INIT; m_ticks = 0; m_sq = 1'b0;
   endtask

   // Game rules stated directly: counts of ticks since game-over entry, arithmetic digits.
   task automatic model_step(input bit h, input bit m, input bit t, input bit s);
      bit rise;
      rise = s & ~m_sq;
      m_sq = s;
      case (m_st)
         M_IDLE, M_WAIT: begin
            if (rise) begin
               m_pts = 0; m_lives = LIVES_INIT; m_st = M_PLAY;
            end else if (t) m_ticks++;
         end
         M_PLAY: begin
            if (h && m_pts < MAX_POINTS) m_pts++;
            if (m) begin
               m_lives--;
               if (m_lives == 0) begin m_st = M_HOLD; m_ticks = 0; end
            end
         end
         default: begin
            if (t) begin
               m_ticks++;
               if (m_ticks == HOLD_FRAMES) m_st = M_WAIT;
            end
         end
      endcase
   endtask

   task automatic check_all();
      bit go;
      int disp;
      go = (m_st == M_HOLD) || (m_st == M_WAIT);
`ifdef GAME_OVER_BLINK_EN
      disp = (go && ((m_ticks / BLINK_FRAMES) % 2 == 0)) ? 1 : 0;
`else
      disp = go ? 1 : 0;
`endif
      chk("playing",    int'(playing),      (m_st == M_PLAY) ? 1 : 0);
      chk("game_over",  int'(game_over),    go ? 1 : 0);
      chk("display_en", int'(display_en),   disp);
      chk("points",     int'(points),       m_pts);
      chk("tens",       int'(points_tens),  m_pts / 10);
      chk("units",      int'(points_units), m_pts % 10);
      chk("lives",      int'(lives),        m_lives);
   endtask

   task automatic step(input bit h, input bit m, input bit t, input bit s);
      hit_evt = h; miss_evt = m; frame_tick = t; start_btn = s;
      @(posedge clk);
      model_step(h, m, t, s);
      #1;
      check_all();
   endtask

   initial begin
      bit s;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      chk("rst_lives", int'(lives), 3);
      rst = 1'b0;

      // start and score
      step(0, 0, 0, 1);
      chk("start_play", int'(playing), 1);
      chk("start_lives", int'(lives), 3);
      step(0, 0, 0, 0);
      repeat (12) step(1, 0, 0, 0);
      chk("pts12", int'(points), 12);
      chk("pts12_t", int'(points_tens), 1);
      chk("pts12_u", int'(points_units), 2);

      // saturation and game over
      repeat (40) step(1, 0, 1, 0);
      chk("sat", int'(points), 31);
      chk("sat_t", int'(points_tens), 3);
      chk("sat_u", int'(points_units), 1);
      repeat (2) step(0, 1, 0, 0);
      chk("not_over", int'(game_over), 0);
      step(0, 1, 0, 0);
      chk("go_rise", int'(game_over), 1);
      chk("go_play", int'(playing), 0);
      chk("go_lives", int'(lives), 0);
      chk("go_disp", int'(display_en), 1);

      // hold: start edges during the first 119 ticks are ignored
      for (int i = 0; i < HOLD_FRAMES - 1; i++) step(1, 1, 1, (i % 2) == 1);
      chk("hold_play", int'(playing), 0);
      chk("hold_go", int'(game_over), 1);
      chk("hold_pts", int'(points), 31);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      chk("restart_play", int'(playing), 1);
      chk("restart_pts", int'(points), 0);
      chk("restart_lives", int'(lives), 3);
      step(0, 0, 0, 0);

      // simultaneous hit and fatal miss
      repeat (9) step(1, 0, 0, 0);
      repeat (2) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("sim_pts", int'(points), 10);
      chk("sim_t", int'(points_tens), 1);
      chk("sim_u", int'(points_units), 0);
      chk("sim_go", int'(game_over), 1);

      // run through hold and blink into wait, then reset asynchronously
      repeat (HOLD_FRAMES + 70) step(0, 0, 1, 0);
      chk("wait_go", int'(game_over), 1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("async_go", int'(game_over), 0);
      #2 rst = 1'b0;
      @(negedge clk);

      // random traffic
      s = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 5) == 0) s = ~s;
         step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 1) == 1, s);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Game-state sequencer that drives the end-of-game text overlay. Tracks score and lives from gameplay event strobes, runs the IDLE/PLAYING/GAME_OVER flow on frame ticks, and presents registered `game_over`, `points` and pre-split decimal digits to the overlay renderer. The renderer therefore needs no divider. Sits between game logic and the VGA overlay, in the `clk` domain.

## Interface
- `LIVES_INIT`, 3: lives loaded at reset and on game start (1..7).
- `MAX_POINTS`, 31: score saturation value. Must fit in 5 bits.
- `HOLD_FRAMES`, 120: frame ticks in GAME_OVER_HOLD before a restart is accepted (1..255).
- `BLINK_FRAMES`, 30: frame ticks per blink half-period (1..255). Used only when blink is compiled in.
- `clk` input 1: system/pixel clock. All logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_btn` input 1: level from a debounced button. Only its rising edge acts.
- `hit_evt` input 1: one-cycle strobe that adds one point.
- `miss_evt` input 1: one-cycle strobe that costs one life.
- `frame_tick` input 1: one-cycle strobe per frame (start of vsync).
- `playing` output 1: high in PLAYING.
- `game_over` output 1: high in GAME_OVER_HOLD and GAME_OVER_WAIT.
- `display_en` output 1: overlay visibility qualifier.
- `points` output 5: current score, binary.
- `points_tens` output 4: `points / 10`.
- `points_units` output 4: `points % 10`.
- `lives` output 3: remaining lives.

## Operation
- **States:** IDLE, PLAYING, GAME_OVER_HOLD, GAME_OVER_WAIT.
- **Start edge:** `start_rise = start_btn & ~start_q`, with `start_q` registered.
- **IDLE:**
  - On `start_rise`, clear `points`, load `lives = LIVES_INIT`, go to PLAYING.
  - `hit_evt` and `miss_evt` are ignored.
- **PLAYING:**
  - On `hit_evt`, `points` increments and saturates at `MAX_POINTS`.
  - On `miss_evt`, `lives` decrements.
  - If the decrement reaches 0, go to GAME_OVER_HOLD and clear `frame_cnt`.
  - `start_rise` is ignored.
- **GAME_OVER_HOLD:**
  - `frame_cnt` increments on `frame_tick`.
  - On the tick where `frame_cnt == HOLD_FRAMES-1`, go to GAME_OVER_WAIT.
  - `start_rise`, `hit_evt` and `miss_evt` are ignored.
  - `points` is frozen.
- **GAME_OVER_WAIT:**
  - On `start_rise`, clear `points`, load `lives = LIVES_INIT`, go to PLAYING.
  - Events are ignored.
- **Simultaneous `hit_evt` and `miss_evt` in PLAYING:** both apply in the same cycle. The final score includes the hit even when that miss ends the game.
- **Digit split:** `points_tens` and `points_units` are registered from the next-state `points` value, so all three are always mutually consistent.
  - Values run 0..3 for tens and 0..9 for units at `MAX_POINTS = 31`.
- **`lives` underflow:** impossible, because a miss that takes `lives` to 0 leaves PLAYING.

## Timing
- **Reset values:** state IDLE, `points` 0, `points_tens` 0, `points_units` 0, `lives` `LIVES_INIT`, `playing` 0, `game_over` 0, `display_en` 0, `frame_cnt` 0, blink phase 1, `start_q` 0.
- **Latency:** all outputs are registered. An event or edge at cycle N is visible at N+1.
  - `start_btn` rising at cycle N shows as `playing` at N+1 (`start_q` absorbs edge detection in the same cycle).
- **Game-over entry:** `game_over` rises the cycle after the fatal miss. `display_en` rises at the same time.
- **Hold length:** `game_over` stays high for at least `HOLD_FRAMES` frame ticks before a restart is possible.
- **Reset mid-operation:** `rst` asserted in any state forces the reset values immediately (asynchronous). Deassertion returns operation to IDLE.
- **`frame_tick` outside the game-over states:** ignored. `frame_cnt` is held at 0.

## Configuration
- `GAME_OVER_BLINK_EN`:
  - **Defined:** `display_en` toggles every `BLINK_FRAMES` frame ticks while `game_over`, starting high on game-over entry. A dedicated blink counter runs alongside `frame_cnt` and is cleared on entry. `display_en` is 0 outside the game-over states.
  - **Undefined:** `display_en` equals `game_over` (registered), and no blink counter is built.

## Structure
- **Shared package `game_pkg`:** state encoding (`ST_IDLE`=0, `ST_PLAYING`=1, `ST_GO_HOLD`=2, `ST_GO_WAIT`=3), `POINTS_W` = 5, `LIVES_W` = 3.
- **Sub-module `bin_to_bcd2`:** combinational 5-bit binary to tens/units split using compare-subtract, no divider. Reused by the overlay and the score HUD.

## Test plan
- **Start and score:** reset, then `start_btn` rise → `playing` = 1 next cycle, `lives` = 3. Then 12 `hit_evt` → `points` = 12, `points_tens` = 1, `points_units` = 2.
- **Saturation and game over:** 40 hits → `points` stays 31, digits 3/1. Then 3 misses → `game_over` = 1 the cycle after the third miss, `playing` = 0, `lives` = 0.
- **Simultaneous events:** at `points` = 9 and `lives` = 1, assert `hit_evt` and `miss_evt` together → `points` = 10 (digits 1/0), `game_over` = 1.
- **Hold, then restart:** `start_rise` during the first 119 frame ticks is ignored. After the 120th tick (defaults), `start_rise` → `playing` = 1, `points` = 0, `lives` = 3.
- **Blink, with `GAME_OVER_BLINK_EN` defined:** `display_en` is 1 for 30 ticks, 0 for 30 ticks, and repeats. **Without the macro:** `display_en` tracks `game_over` exactly.
- **Reset mid-game:** assert `rst` asynchronously between clock edges in GAME_OVER_WAIT → all outputs take their reset values before the next clock edge.
